// File: rtl/mem_req_buffer.sv
// Request/response buffer between the load/store queue and the data cache.
// Queues requests in a FIFO, registers cache responses, tracks pending IDs and flags protocol errors.
module mem_req_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int IDW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr_in,
    input  logic [DW-1:0]     data_in,
    input  logic              rw_in,
    input  logic [IDW-1:0]    id_in,
    input  logic              valid_in,
    output logic              stall_out,
    output logic [AW-1:0]     addr_out_M,
    output logic [DW-1:0]     data_out_M,
    output logic              rw_out_M,
    output logic [IDW-1:0]    id_out_M,
    output logic              valid_out_M,
    input  logic              stall_in_M,
    input  logic              ready_in_M,
    input  logic [IDW-1:0]    id_in_M,
    input  logic [DW-1:0]     data_in_M,
    output logic              ready_out,
    output logic [IDW-1:0]    id_out,
    output logic [DW-1:0]     data_out,
    output logic [2**IDW-1:0] pending_out,
    output logic              err_out
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int NID = 2 ** IDW;
    localparam int EW  = AW + DW + 1 + IDW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;
    logic [NID-1:0] pending_reg;
    logic [NID-1:0] pending_clr;
    logic [NID-1:0] pending_next;

    logic pop;
    logic accept;
    logic overflow_err;
    logic dup_err;
    logic resp_err;

    assign stall_out = (count_reg == FULL);
    assign pop       = (count_reg != '0) && !stall_in_M;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign accept       = valid_in && (!stall_out || pop);
    assign overflow_err = valid_in && !accept;

    always_comb begin
        count_next = count_reg;
        if (accept && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !accept) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Response clears are applied before request sets, so a same-edge
    // answer and reissue of one ID leaves the bit set without an error.
    genvar gi;
    generate
        for (gi = 0; gi < NID; gi++) begin : g_pending
            assign pending_clr[gi]  = pending_reg[gi] & ~(ready_in_M && (id_in_M == IDW'(gi)));
            assign pending_next[gi] = pending_clr[gi] | (accept && (id_in == IDW'(gi)));
        end
    endgenerate

    assign dup_err  = accept && pending_clr[id_in];
    assign resp_err = ready_in_M && !pending_reg[id_in_M];
    assign pending_out = pending_reg;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= {addr_in, data_in, rw_in, id_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            pending_reg <= '0;
            addr_out_M  <= '0;
            data_out_M  <= '0;
            rw_out_M    <= 1'b0;
            id_out_M    <= '0;
            valid_out_M <= 1'b0;
            ready_out   <= 1'b0;
            id_out      <= '0;
            data_out    <= '0;
            err_out     <= 1'b0;
        end else begin
            count_reg   <= count_next;
            pending_reg <= pending_next;
            valid_out_M <= pop;
            ready_out   <= ready_in_M;
            id_out      <= id_in_M;
            data_out    <= data_in_M;
            err_out     <= overflow_err | dup_err | resp_err;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                {addr_out_M, data_out_M, rw_out_M, id_out_M} <= mem[rd_ptr_reg];
            end
        end
    end
endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed testbench for mem_req_buffer: issue latency, overflow, responses,
// full-FIFO slot reuse and asynchronous reset.
module tb_mem_req_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        rw_in;
    logic [3:0]  id_in;
    logic        valid_in;
    logic        stall_out;
    logic [31:0] addr_out_M;
    logic [31:0] data_out_M;
    logic        rw_out_M;
    logic [3:0]  id_out_M;
    logic        valid_out_M;
    logic        stall_in_M;
    logic        ready_in_M;
    logic [3:0]  id_in_M;
    logic [31:0] data_in_M;
    logic        ready_out;
    logic [3:0]  id_out;
    logic [31:0] data_out;
    logic [15:0] pending_out;
    logic        err_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_req_buffer #(.DEPTH(4), .AW(32), .DW(32), .IDW(4)) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .data_in(data_in), .rw_in(rw_in), .id_in(id_in),
        .valid_in(valid_in), .stall_out(stall_out),
        .addr_out_M(addr_out_M), .data_out_M(data_out_M), .rw_out_M(rw_out_M),
        .id_out_M(id_out_M), .valid_out_M(valid_out_M), .stall_in_M(stall_in_M),
        .ready_in_M(ready_in_M), .id_in_M(id_in_M), .data_in_M(data_in_M),
        .ready_out(ready_out), .id_out(id_out), .data_out(data_out),
        .pending_out(pending_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr_in = '0; data_in = '0; rw_in = 1'b0; id_in = '0; valid_in = 1'b0;
        stall_in_M = 1'b0; ready_in_M = 1'b0; id_in_M = '0; data_in_M = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        n_checks++;
        if ({valid_out_M, ready_out, err_out, stall_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", {valid_out_M, ready_out, err_out, stall_out});
        end
        n_checks++;
        if (pending_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_pending got=%h exp=0000", pending_out);
        end
        #3 rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({valid_out_M, ready_out, err_out, stall_out, pending_out} !== 20'h0) begin
            n_fail++;
            $display("FAIL idle_after_release got=%h exp=0", {valid_out_M, ready_out, err_out, stall_out, pending_out});
        end
        n_checks++;
        if ({addr_out_M, data_out_M, id_out_M, rw_out_M, id_out, data_out} !== 101'h0) begin
            n_fail++;
            $display("FAIL idle_data_zero got=%h exp=0", {addr_out_M, data_out_M, id_out_M, rw_out_M, id_out, data_out});
        end
        $display("reset released, outputs idle");
    endtask

    task automatic test_single_load();
        valid_in = 1'b1; id_in = 4'd3; addr_in = 32'h40; rw_in = 1'b0; data_in = '0;
        step();
        valid_in = 1'b0;
        n_checks++;
        if (valid_out_M !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_no_bypass got=%b exp=0", valid_out_M);
        end
        n_checks++;
        if (pending_out !== 16'h0008) begin
            n_fail++;
            $display("FAIL ld_pending got=%h exp=0008", pending_out);
        end
        step();
        n_checks++;
        if ({valid_out_M, addr_out_M, rw_out_M, id_out_M} !== {1'b1, 32'h40, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL ld_issue got v=%b a=%h rw=%b id=%0d exp v=1 a=00000040 rw=0 id=3",
                     valid_out_M, addr_out_M, rw_out_M, id_out_M);
        end
        $display("issue id=%0d addr=%h rw=%b", id_out_M, addr_out_M, rw_out_M);
        step();
        n_checks++;
        if ({valid_out_M, addr_out_M} !== {1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL ld_pulse_hold got v=%b a=%h exp v=0 a=00000040", valid_out_M, addr_out_M);
        end
    endtask

    task automatic test_response();
        ready_in_M = 1'b1; id_in_M = 4'd3; data_in_M = 32'hDEADBEEF;
        step();
        n_checks++;
        if ({ready_out, id_out, data_out, err_out} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL resp_fwd got r=%b id=%0d d=%h e=%b exp r=1 id=3 d=deadbeef e=0",
                     ready_out, id_out, data_out, err_out);
        end
        n_checks++;
        if (pending_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL resp_clear got=%h exp=0000", pending_out);
        end
        $display("response id=%0d data=%h", id_out, data_out);
        step();
        ready_in_M = 1'b0;
        n_checks++;
        if ({ready_out, err_out} !== 2'b11) begin
            n_fail++;
            $display("FAIL resp_repeat_err got r,e=%b exp 11", {ready_out, err_out});
        end
        $display("response id=%0d repeated, err=%b", id_out, err_out);
        step();
        n_checks++;
        if ({ready_out, err_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL resp_err_pulse got r,e=%b exp 00", {ready_out, err_out});
        end
    endtask

    task automatic test_overflow();
        stall_in_M = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; id_in = 4'(i); addr_in = 32'h100 + i; rw_in = i[0]; data_in = 32'h11 * i;
            step();
            $display("request id=%0d stall_out=%b err=%b", i, stall_out, err_out);
            n_checks++;
            if (stall_out !== (i >= 3)) begin
                n_fail++;
                $display("FAIL ovf_stall_%0d got=%b exp=%b", i, stall_out, (i >= 3));
            end
            n_checks++;
            if (err_out !== (i == 4)) begin
                n_fail++;
                $display("FAIL ovf_err_%0d got=%b exp=%b", i, err_out, (i == 4));
            end
        end
        valid_in = 1'b0;
        step();
        n_checks++;
        if ({err_out, stall_out, valid_out_M} !== 3'b010) begin
            n_fail++;
            $display("FAIL ovf_err_once got e,s,v=%b exp 010", {err_out, stall_out, valid_out_M});
        end
        n_checks++;
        if (pending_out !== 16'h000F) begin
            n_fail++;
            $display("FAIL ovf_pending got=%h exp=000f", pending_out);
        end
        stall_in_M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            $display("issue id=%0d addr=%h rw=%b data=%h", id_out_M, addr_out_M, rw_out_M, data_out_M);
            n_checks++;
            if ({valid_out_M, id_out_M, addr_out_M, rw_out_M, data_out_M} !==
                {1'b1, 4'(i), 32'h100 + i, i[0], 32'h11 * i}) begin
                n_fail++;
                $display("FAIL drain_%0d got v=%b id=%0d a=%h rw=%b d=%h", i, valid_out_M, id_out_M,
                         addr_out_M, rw_out_M, data_out_M);
            end
        end
        step();
        n_checks++;
        if ({valid_out_M, stall_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_empty got v,s=%b exp 00", {valid_out_M, stall_out});
        end
        for (int i = 0; i < 4; i++) begin
            ready_in_M = 1'b1; id_in_M = 4'(i); data_in_M = 32'hA0 + i;
            step();
            $display("response id=%0d data=%h err=%b", id_out, data_out, err_out);
            n_checks++;
            if ({ready_out, id_out, data_out, err_out} !== {1'b1, 4'(i), 32'hA0 + i, 1'b0}) begin
                n_fail++;
                $display("FAIL resp_seq_%0d got r=%b id=%0d d=%h e=%b", i, ready_out, id_out, data_out, err_out);
            end
        end
        ready_in_M = 1'b0;
        step();
        n_checks++;
        if (pending_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL resp_seq_pending got=%h exp=0000", pending_out);
        end
    endtask

    task automatic test_full_pop_accept();
        stall_in_M = 1'b1;
        for (int i = 8; i < 12; i++) begin
            valid_in = 1'b1; id_in = 4'(i); addr_in = 32'h800 + i; rw_in = 1'b1; data_in = 32'(i);
            step();
        end
        n_checks++;
        if (stall_out !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall got=%b exp=1", stall_out);
        end
        stall_in_M = 1'b0; id_in = 4'd7; addr_in = 32'h700; rw_in = 1'b0; data_in = 32'h77;
        step();
        valid_in = 1'b0;
        $display("pop id=%0d with accept id=7, stall_out=%b err=%b", id_out_M, stall_out, err_out);
        n_checks++;
        if ({valid_out_M, id_out_M, stall_out, err_out} !== {1'b1, 4'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL full_reuse got v=%b id=%0d s=%b e=%b exp v=1 id=8 s=1 e=0",
                     valid_out_M, id_out_M, stall_out, err_out);
        end
        n_checks++;
        if (pending_out !== 16'h0F80) begin
            n_fail++;
            $display("FAIL full_pending got=%h exp=0f80", pending_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            $display("issue id=%0d addr=%h", id_out_M, addr_out_M);
            n_checks++;
            if ({valid_out_M, id_out_M} !== {1'b1, (i == 3) ? 4'd7 : 4'(9 + i)}) begin
                n_fail++;
                $display("FAIL full_drain_%0d got v=%b id=%0d exp v=1 id=%0d", i, valid_out_M, id_out_M,
                         (i == 3) ? 7 : 9 + i);
            end
        end
        n_checks++;
        if ({addr_out_M, rw_out_M, data_out_M} !== {32'h700, 1'b0, 32'h77}) begin
            n_fail++;
            $display("FAIL full_reused_slot got a=%h rw=%b d=%h exp a=00000700 rw=0 d=00000077",
                     addr_out_M, rw_out_M, data_out_M);
        end
        step();
    endtask

    task automatic test_async_reset();
        stall_in_M = 1'b1;
        for (int i = 1; i < 3; i++) begin
            valid_in = 1'b1; id_in = 4'(i); addr_in = 32'h200 + i; rw_in = 1'b0; data_in = '0;
            step();
        end
        valid_in = 1'b0;
        #3 rst = 1'b0;
        #1;
        $display("async reset asserted mid-cycle");
        n_checks++;
        if ({valid_out_M, stall_out, err_out, ready_out, pending_out} !== 20'h0) begin
            n_fail++;
            $display("FAIL async_rst_flags got=%h exp=0", {valid_out_M, stall_out, err_out, ready_out, pending_out});
        end
        n_checks++;
        if (addr_out_M !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst_addr got=%h exp=00000000", addr_out_M);
        end
        #2 rst = 1'b1;
        stall_in_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (valid_out_M !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst_no_issue_%0d got=%b exp=0", i, valid_out_M);
            end
        end
        ready_in_M = 1'b1; id_in_M = 4'd2; data_in_M = 32'h5;
        step();
        ready_in_M = 1'b0;
        $display("response id=%0d after reset, err=%b", id_out, err_out);
        n_checks++;
        if ({ready_out, id_out, err_out} !== {1'b1, 4'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL stale_resp_err got r=%b id=%0d e=%b exp r=1 id=2 e=1", ready_out, id_out, err_out);
        end
        step();
        n_checks++;
        if (err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_err_pulse got=%b exp=0", err_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_response();
        test_overflow();
        test_full_pop_accept();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
